// File: rtl/streaming_dwc_upsize.sv
// streaming_dwc_upsize
// AXI-Stream width upsizer. It packs RATIO narrow input words into one wide
// output word, with the first-received word in the least significant lane.
// The converter is frame-aware. When a frame ends part-way through a group,
// that group is emitted early and its unused upper lanes are set to zero.
// The lane counter then restarts at lane 0 for the next frame.
// A single output register holds the packed word. Non-completing input words
// are always accepted. A completing word is stalled only while the output
// register is full and the consumer is not draining it.

module streaming_dwc_upsize #(
    parameter int IN_WIDTH    = 8,
    parameter int RATIO       = 4,      // must be >= 2
    parameter int FRAME_WORDS = 1024,   // must be >= 1
    localparam int OUT_WIDTH  = IN_WIDTH * RATIO
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic [IN_WIDTH-1:0]  in0_V_V_TDATA,
    input  logic                 in0_V_V_TVALID,
    output logic                 in0_V_V_TREADY,
    output logic [OUT_WIDTH-1:0] out_V_V_TDATA,
    output logic                 out_V_V_TVALID,
    input  logic                 out_V_V_TREADY,
    output logic                 frame_done
);

    localparam int LANE_W = $clog2(RATIO);
    localparam int FC_W   = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(RATIO - 1);
    localparam logic [FC_W-1:0]   FC_LAST   = FC_W'(FRAME_WORDS - 1);

    // Architectural state
    logic [OUT_WIDTH-1:0] acc_q, acc_d;
    logic [LANE_W-1:0]    lane_q, lane_d;
    logic [FC_W-1:0]      frame_cnt_q, frame_cnt_d;
    logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    // Set when the held output word closes a frame.
    logic                 out_last_q, out_last_d;
    logic                 frame_done_q, frame_done_d;

    // Decoded control
    logic                 lane_last_s;
    logic                 frame_last_s;
    logic                 completing_s;
    logic                 in_ready_s;
    logic                 in_fire_s;
    logic                 out_fire_s;
    logic [OUT_WIDTH-1:0] acc_wr_s;
    logic [OUT_WIDTH-1:0] packed_s;

    // Handshake decode: the completing word waits only for room in the output register
    always_comb begin
        lane_last_s  = (lane_q == LANE_LAST);
        frame_last_s = (frame_cnt_q == FC_LAST);
        completing_s = lane_last_s | frame_last_s;
        in_ready_s   = ~completing_s | ~out_valid_q | out_V_V_TREADY;
        in_fire_s    = in0_V_V_TVALID & in_ready_s;
        out_fire_s   = out_valid_q & out_V_V_TREADY;
    end

    // Lane insertion: the accumulator with the incoming word written at the current lane
    always_comb begin
        acc_wr_s = acc_q;
        acc_wr_s[int'(lane_q) * IN_WIDTH +: IN_WIDTH] = in0_V_V_TDATA;
    end

    // Output packing: lanes above the current one are forced to zero to pad a short final group
    always_comb begin
        packed_s = {OUT_WIDTH{1'b0}};
        for (int k = 0; k < RATIO; k++) begin
            if (k <= int'(lane_q)) begin
                packed_s[k * IN_WIDTH +: IN_WIDTH] = acc_wr_s[k * IN_WIDTH +: IN_WIDTH];
            end else begin
                packed_s[k * IN_WIDTH +: IN_WIDTH] = {IN_WIDTH{1'b0}};
            end
        end
    end

    // Next-state logic for the accumulator, counters and output register
    always_comb begin
        acc_d        = acc_q;
        lane_d       = lane_q;
        frame_cnt_d  = frame_cnt_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        frame_done_d = out_fire_s & out_last_q;

        if (in_fire_s) begin
            if (completing_s) begin
                out_data_d = packed_s;
                out_last_d = frame_last_s;
                acc_d      = {OUT_WIDTH{1'b0}};
                lane_d     = {LANE_W{1'b0}};
                if (frame_last_s) begin
                    frame_cnt_d = {FC_W{1'b0}};
                end else begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end
            end else begin
                acc_d       = acc_wr_s;
                lane_d      = lane_q + 1'b1;
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end else begin
            acc_d = acc_q;
        end

        // A completion that coincides with a drain reloads the register and keeps it valid.
        if (in_fire_s && completing_s) begin
            out_valid_d = 1'b1;
        end else if (out_fire_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers: asynchronous reset discards any partial group and pending output
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc_q        <= {OUT_WIDTH{1'b0}};
            lane_q       <= {LANE_W{1'b0}};
            frame_cnt_q  <= {FC_W{1'b0}};
            out_data_q   <= {OUT_WIDTH{1'b0}};
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            lane_q       <= lane_d;
            frame_cnt_q  <= frame_cnt_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign in0_V_V_TREADY = in_ready_s;
    assign out_V_V_TDATA  = out_data_q;
    assign out_V_V_TVALID = out_valid_q;
    assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_streaming_dwc_upsize.sv
// Testbench for streaming_dwc_upsize.
// Three instances are exercised: FRAME_WORDS of 1024, 6 and 7, each with
// RATIO=4 and IN_WIDTH=8.
// A reference model runs at every falling edge. It records the accepted input
// words, groups them by ratio and by frame position, and queues the words the
// design is expected to emit. The output register is a single slot, so
// TVALID must be high exactly when that queue is non-empty.

module tb_streaming_dwc_upsize;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data    [NI];
    logic        in_valid   [NI];
    logic        in_ready   [NI];
    logic [31:0] out_data   [NI];
    logic        out_valid  [NI];
    logic        out_ready  [NI];
    logic        frame_done [NI];

    int fw [NI] = '{1024, 6, 7};

    always #5 clk = ~clk;

    streaming_dwc_upsize #(.IN_WIDTH(8), .RATIO(4), .FRAME_WORDS(1024)) u0 (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .in0_V_V_TDATA(in_data[0]), .in0_V_V_TVALID(in_valid[0]), .in0_V_V_TREADY(in_ready[0]),
        .out_V_V_TDATA(out_data[0]), .out_V_V_TVALID(out_valid[0]), .out_V_V_TREADY(out_ready[0]),
        .frame_done(frame_done[0]));

    streaming_dwc_upsize #(.IN_WIDTH(8), .RATIO(4), .FRAME_WORDS(6)) u1 (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .in0_V_V_TDATA(in_data[1]), .in0_V_V_TVALID(in_valid[1]), .in0_V_V_TREADY(in_ready[1]),
        .out_V_V_TDATA(out_data[1]), .out_V_V_TVALID(out_valid[1]), .out_V_V_TREADY(out_ready[1]),
        .frame_done(frame_done[1]));

    streaming_dwc_upsize #(.IN_WIDTH(8), .RATIO(4), .FRAME_WORDS(7)) u2 (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .in0_V_V_TDATA(in_data[2]), .in0_V_V_TVALID(in_valid[2]), .in0_V_V_TREADY(in_ready[2]),
        .out_V_V_TDATA(out_data[2]), .out_V_V_TVALID(out_valid[2]), .out_V_V_TREADY(out_ready[2]),
        .frame_done(frame_done[2]));

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state. Each expected entry is {last_of_frame, data}.
    logic [32:0] exp_q [NI][$];
    logic [31:0] obs_q [NI][$];
    logic [31:0] grp_data   [NI];
    int          grp_cnt    [NI];
    int          fpos       [NI];
    logic        fd_exp     [NI];
    int          fd_cnt     [NI];
    logic        prev_stall [NI];
    logic [31:0] prev_data  [NI];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic feed(input int g, input logic [7:0] w);
        bit done;
        done = 1'b0;
        in_data[g]  = w;
        in_valid[g] = 1'b1;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (in_ready[g]) done = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid[g] = 1'b0;
        if (!done) begin
            n_cmp++;
            n_fail++;
            $error("FAIL feed_timeout: inst=%0d word=%0h never accepted", g, w);
        end
    endtask

    // Reference model and protocol monitor, sampled on the falling edge
    always @(negedge clk) begin
        for (int g = 0; g < NI; g++) begin
            if (!rst_n) begin
                exp_q[g].delete();
                grp_data[g]   = 32'd0;
                grp_cnt[g]    = 0;
                fpos[g]       = 0;
                fd_exp[g]     = 1'b0;
                fd_cnt[g]     = 0;
                prev_stall[g] = 1'b0;
                check($sformatf("rst_valid%0d", g), out_valid[g], 64'd0);
                check($sformatf("rst_data%0d", g), out_data[g], 64'd0);
                check($sformatf("rst_fdone%0d", g), frame_done[g], 64'd0);
            end else begin
                check($sformatf("valid_occupancy%0d", g), out_valid[g], (exp_q[g].size() != 0));
                check($sformatf("frame_done%0d", g), frame_done[g], fd_exp[g]);
                if (frame_done[g]) fd_cnt[g]++;
                if (prev_stall[g]) begin
                    check($sformatf("hold_valid%0d", g), out_valid[g], 64'd1);
                    check($sformatf("hold_data%0d", g), out_data[g], prev_data[g]);
                end
                fd_exp[g] = 1'b0;
                if (out_valid[g] && out_ready[g]) begin
                    if (exp_q[g].size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $error("FAIL unexpected_out%0d: observed=%0h expected=none", g, out_data[g]);
                    end else begin
                        logic [32:0] e;
                        e = exp_q[g].pop_front();
                        check($sformatf("out_data%0d", g), out_data[g], e[31:0]);
                        fd_exp[g] = e[32];
                    end
                    obs_q[g].push_back(out_data[g]);
                end
                prev_stall[g] = out_valid[g] && !out_ready[g];
                prev_data[g]  = out_data[g];
                if (in_valid[g] && in_ready[g]) begin
                    grp_data[g] = grp_data[g] | (32'(in_data[g]) << (8 * grp_cnt[g]));
                    grp_cnt[g]++;
                    fpos[g]++;
                    if (grp_cnt[g] == 4 || fpos[g] == fw[g]) begin
                        exp_q[g].push_back({(fpos[g] == fw[g]), grp_data[g]});
                        grp_data[g] = 32'd0;
                        grp_cnt[g]  = 0;
                        if (fpos[g] == fw[g]) fpos[g] = 0;
                    end
                end
            end
        end
    end

    logic [31:0] t2_exp [4] = '{32'h44332211, 32'h00006655, 32'hAA998877, 32'h0000CCBB};

    initial begin
        int   idx;
        int   sent;
        bit   fire;
        logic [31:0] ew;

        rst_n = 1'b0;
        for (int g = 0; g < NI; g++) begin
            in_data[g]   = 8'd0;
            in_valid[g]  = 1'b0;
            out_ready[g] = 1'b0;
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        for (int g = 0; g < NI; g++) check($sformatf("ready_after_reset%0d", g), in_ready[g], 64'd1);
        @(posedge clk);
        #1;

        // Basic pack, unstalled consumer
        out_ready[0] = 1'b1;
        feed(0, 8'h11); feed(0, 8'h22); feed(0, 8'h33); feed(0, 8'h44);
        @(negedge clk);
        check("t1_valid", out_valid[0], 64'd1);
        check("t1_data", out_data[0], 64'h44332211);
        check("t1_fdone", frame_done[0], 64'd0);
        @(negedge clk);
        check("t1_valid_one_cycle", out_valid[0], 64'd0);
        @(posedge clk);
        #1;

        // Backpressure: consumer stalled for 10 cycles while 8 words are offered
        obs_q[0].delete();
        out_ready[0] = 1'b0;
        idx = 0;
        in_data[0]  = 8'd1;
        in_valid[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            fire = in_valid[0] && in_ready[0];
            @(posedge clk);
            #1;
            if (fire) idx++;
            if (idx < 8) in_data[0] = 8'(idx + 1); else in_valid[0] = 1'b0;
        end
        check("bp_accepted", idx, 64'd7);
        @(negedge clk);
        check("bp_ready_low", in_ready[0], 64'd0);
        check("bp_valid", out_valid[0], 64'd1);
        check("bp_data", out_data[0], 64'h04030201);
        @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
        for (int c = 0; c < 20 && idx < 8; c++) begin
            @(negedge clk);
            fire = in_valid[0] && in_ready[0];
            @(posedge clk);
            #1;
            if (fire) idx++;
            if (idx >= 8) in_valid[0] = 1'b0;
        end
        in_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("bp_count", obs_q[0].size(), 64'd2);
        check("bp_word0", obs_q[0][0], 64'h04030201);
        check("bp_word1", obs_q[0][1], 64'h08070605);
        @(posedge clk);
        #1;

        // Reset in the middle of a group
        feed(0, 8'hAA); feed(0, 8'hBB);
        #2;
        rst_n = 1'b0;
        for (int g = 0; g < NI; g++) in_valid[g] = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        obs_q[0].delete();
        @(negedge clk);
        check("mid_rst_ready", in_ready[0], 64'd1);
        check("mid_rst_valid", out_valid[0], 64'd0);
        @(posedge clk);
        #1;
        feed(0, 8'h01); feed(0, 8'h02); feed(0, 8'h03); feed(0, 8'h04);
        repeat (2) @(negedge clk);
        check("mid_rst_count", obs_q[0].size(), 64'd1);
        check("mid_rst_word", obs_q[0][0], 64'h04030201);
        @(posedge clk);
        #1;

        // Short frames (6 words) with padded tails
        out_ready[1] = 1'b1;
        obs_q[1].delete();
        for (int k = 1; k <= 12; k++) feed(1, 8'(k * 17));
        repeat (3) @(negedge clk);
        check("t2_count", obs_q[1].size(), 64'd4);
        for (int k = 0; k < 4; k++) check($sformatf("t2_word%0d", k), obs_q[1][k], t2_exp[k]);
        check("t2_fdone_count", fd_cnt[1], 64'd2);
        @(posedge clk);
        #1;

        // Continuous streaming: ready must never drop
        obs_q[0].delete();
        out_ready[0] = 1'b1;
        idx = 0;
        in_data[0]  = 8'd0;
        in_valid[0] = 1'b1;
        for (int c = 0; c < 4300 && idx < 4096; c++) begin
            @(negedge clk);
            check("stream_ready", in_ready[0], 64'd1);
            fire = in_ready[0];
            @(posedge clk);
            #1;
            if (fire) idx++;
            in_data[0] = 8'(idx);
            if (idx >= 4096) in_valid[0] = 1'b0;
        end
        in_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("stream_count", obs_q[0].size(), 64'd1024);
        for (int k = 0; k < 1024; k++) begin
            ew = {8'(4 * k + 3), 8'(4 * k + 2), 8'(4 * k + 1), 8'(4 * k)};
            if (k < obs_q[0].size()) check("stream_word", obs_q[0][k], ew);
        end
        @(posedge clk);
        #1;

        // Random valid/ready toggling with 7-word frames
        obs_q[2].delete();
        sent = 0;
        in_valid[2] = 1'b0;
        for (int c = 0; c < 60000 && sent < 10003; c++) begin
            @(negedge clk);
            fire = in_valid[2] && in_ready[2];
            @(posedge clk);
            #1;
            if (fire) begin
                sent++;
                in_valid[2] = 1'b0;
            end
            if (!in_valid[2] && sent < 10003 && $urandom_range(9, 0) < 7) begin
                in_valid[2] = 1'b1;
                in_data[2]  = 8'($urandom);
            end
            out_ready[2] = ($urandom_range(9, 0) < 6);
        end
        in_valid[2]  = 1'b0;
        out_ready[2] = 1'b1;
        repeat (5) @(negedge clk);
        check("rand_sent", sent, 64'd10003);
        check("rand_fdone_count", fd_cnt[2], 64'd1429);
        check("rand_out_count", obs_q[2].size(), 64'd2858);
        check("rand_drained", exp_q[2].size(), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
